// File: rtl/ack_collect.sv
// Merges NCH slave acknowledges into one registered ack/err pulse for a four-phase master request.
// Optional WAIT timeout is compiled in with ACKC_TIMEOUT_EN; without it WAIT lasts until an ack or req drop.
module ack_collect #(
  parameter int NCH = 4,
  parameter int TMO = 16,
  localparam int SW = $clog2(NCH)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req,
  input  logic [NCH-1:0] ack_in,
  output logic           ack,
  output logic           err,
  output logic           tmo,
  output logic [SW-1:0]  sel,
  output logic           busy
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t          state_q, state_d;
  logic            ack_q, ack_d;
  logic            err_q, err_d;
  logic [SW-1:0]   sel_q, sel_d;
  logic [SW-1:0]   low_idx;
  logic            any_ack;
  logic            multi_ack;

`ifdef ACKC_TIMEOUT_EN
  logic            tmo_q, tmo_d;
  logic [7:0]      cnt_q, cnt_d;
`endif

  // Lowest set index; clearing the lowest bit leaves something only if 2+ bits are set.
  always_comb begin
    low_idx = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (ack_in[i]) low_idx = SW'(i);
    end
    any_ack   = |ack_in;
    multi_ack = |(ack_in & (ack_in - {{(NCH-1){1'b0}}, 1'b1}));
  end

  always_comb begin
    state_d = state_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    sel_d   = sel_q;
`ifdef ACKC_TIMEOUT_EN
    tmo_d   = tmo_q;
    cnt_d   = cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (req) begin
          state_d = S_WAIT;
          sel_d   = '0;
`ifdef ACKC_TIMEOUT_EN
          tmo_d   = 1'b0;
          cnt_d   = '0;
`endif
        end
      end
      S_WAIT: begin
        if (!req) begin
          state_d = S_IDLE;
        end else if (any_ack) begin
          // An ack on the timeout edge takes priority over the timeout.
          state_d = S_DONE;
          ack_d   = !multi_ack;
          err_d   = multi_ack;
          sel_d   = low_idx;
        end
`ifdef ACKC_TIMEOUT_EN
        else if (cnt_q == 8'(TMO - 1)) begin
          state_d = S_DONE;
          err_d   = 1'b1;
          tmo_d   = 1'b1;
        end else if (cnt_q != 8'hFF) begin
          cnt_d = cnt_q + 8'd1;
        end
`endif
      end
      S_DONE: begin
        if (!req) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      sel_q   <= sel_d;
    end
  end

`ifdef ACKC_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      tmo_q <= tmo_d;
      cnt_q <= cnt_d;
    end
  end

  assign tmo = tmo_q;
`else
  assign tmo = 1'b0;
`endif

  assign ack  = ack_q;
  assign err  = err_q;
  assign sel  = sel_q;
  assign busy = (state_q != S_IDLE);

endmodule

// File: doc/ack_collect.md
ACK_COLLECT -- requirements
Module: ack_collect

Interface
REQ-001 Parameter NCH, default 4: number of slave acknowledge channels, legal range 2..16.
REQ-002 Parameter TMO, default 16: timeout limit in WAIT cycles, legal range 2..255.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset; asynchronous, active-high.
REQ-005 req  input  1  master request, active-high; held high until the transaction ends (four-phase handshake).
REQ-006 ack_in  input  NCH  per-slave acknowledge, active-high; bit i belongs to slave i.
REQ-007 ack  output  1  merged acknowledge, active-high, one-cycle pulse per successful transaction.
REQ-008 err  output  1  error pulse, active-high, one cycle; caused by a collision or a timeout.
REQ-009 tmo  output  1  sticky status: the last error was a timeout; cleared on the next accepted req.
REQ-010 sel  output  clog2(NCH)  index of the acknowledging slave; held until the next accepted req.
REQ-011 busy  output  1  high in WAIT and DONE.

Function
REQ-012 The FSM SHALL have three states: IDLE, WAIT and DONE.
REQ-013 IDLE: req sampled high SHALL move the FSM to WAIT, clear the timeout counter, and clear tmo and sel.
REQ-014 WAIT: exactly one ack_in bit sampled high SHALL move the FSM to DONE, set ack=1 for the following cycle only, and load sel with that bit's index.
REQ-015 WAIT: two or more ack_in bits sampled high SHALL move the FSM to DONE, pulse err=1 for one cycle with ack=0, and load sel with the lowest set index.
REQ-016 WAIT: if no ack_in bit is high, the counter SHALL increment once per cycle.
REQ-017 WAIT: if the counter equals TMO-1 and no ack_in bit is high, the FSM SHALL move to DONE with err pulsed and tmo set.
REQ-018 An ack arriving on the same edge as the timeout SHALL win: REQ-014/015 apply and tmo stays 0.
REQ-019 WAIT: req sampled low SHALL abort the transaction: return to IDLE with no ack or err pulse and sel unchanged.
REQ-020 DONE: the FSM SHALL stay in DONE while req is high and return to IDLE on the edge where req is sampled low.
REQ-021 ack_in SHALL be ignored in IDLE and DONE.
REQ-022 Response latency: ack or err SHALL be high in the first DONE cycle, i.e. one cycle after the qualifying ack_in sample.
REQ-023 The counter SHALL be 8 bits wide and saturate; it SHALL never wrap around.
REQ-024 ack and err SHALL never be high in the same cycle.

Reset
REQ-025 When rst is high, the FSM SHALL asynchronously enter IDLE, and ack, err, tmo, sel, busy and the counter SHALL all be 0.
REQ-026 Reset asserted mid-transaction SHALL discard that transaction with no pulse; after rst is released, req SHALL be re-sampled in IDLE.

Configuration
REQ-027 With ACKC_TIMEOUT_EN defined, the counter and tmo SHALL be implemented as specified above.
REQ-028 Without ACKC_TIMEOUT_EN, the counter SHALL be omitted, WAIT SHALL last until an ack or until req drops, and tmo SHALL be tied to 0.

Verification
REQ-029 Scenario: NCH=4, req=1, ack_in=4'b0100 on the 3rd WAIT cycle -> ack=1 for exactly one cycle, sel=2, err=0, busy=1 until req=0.
REQ-030 Scenario: ack_in=4'b1010 in WAIT -> err pulse, ack=0, sel=1, tmo=0.
REQ-031 Scenario: TMO=16 with no ack_in (ACKC_TIMEOUT_EN defined) -> err pulse after 16 WAIT cycles, tmo=1; next req clears tmo. Without the macro -> no err after 100 cycles.
REQ-032 Scenario: ack_in=4'b0001 on the 16th WAIT cycle -> ack pulse, sel=0, err=0, tmo=0.
REQ-033 Scenario: req dropped after 5 WAIT cycles -> IDLE, no pulse; a later ack_in=4'b1000 is ignored.
REQ-034 Scenario: rst asserted in WAIT, then released -> all outputs 0 immediately; a new req completes normally.
